// File: rtl/predicate_sched_pkg.sv
// Shared constants and types for the predicate register block access scheduler.
package predicate_sched_pkg;

    localparam int unsigned LANES        = 16;
    localparam int unsigned WARP_W       = 4;
    localparam int unsigned PREG_AW      = 4;
    localparam int unsigned NUM_WARPS    = 16;
    localparam int unsigned NUM_PREGS    = 16;
    localparam int unsigned NUM_WR       = 2;
    localparam int unsigned NUM_RD       = 4;
    localparam int unsigned STARVE_LIMIT = 4;

    localparam int unsigned WR_IDX_W = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
    localparam int unsigned RD_IDX_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    typedef logic [WARP_W-1:0]  warp_id_t;
    typedef logic [PREG_AW-1:0] preg_addr_t;
    typedef logic [LANES-1:0]   lane_vec_t;

endpackage

// File: rtl/predicate_access_scheduler_if.sv
// Requester handshakes, read responses and predicate register block drive.
interface predicate_access_scheduler_if;
    import predicate_sched_pkg::*;

    logic [NUM_WR-1:0]         wr_req_valid;
    logic [NUM_WR-1:0]         wr_req_ready;
    logic [NUM_WR*WARP_W-1:0]  wr_req_warp;
    logic [NUM_WR*PREG_AW-1:0] wr_req_addr;
    logic [NUM_WR*LANES-1:0]   wr_req_mask;
    logic [NUM_WR*LANES-1:0]   wr_req_data;

    logic [NUM_RD-1:0]         rd_req_valid;
    logic [NUM_RD-1:0]         rd_req_ready;
    logic [NUM_RD*WARP_W-1:0]  rd_req_warp;
    logic [NUM_RD*PREG_AW-1:0] rd_req_addr;
    logic [NUM_RD*LANES-1:0]   rd_req_mask;
    logic [NUM_RD-1:0]         rd_rsp_valid;
    logic [NUM_RD*LANES-1:0]   rd_rsp_data;

    warp_id_t   prb_warp_selector;
    lane_vec_t  prb_write_en;
    preg_addr_t prb_waddr;
    lane_vec_t  prb_wdata;
    lane_vec_t  prb_read_en_0;
    lane_vec_t  prb_read_en_1;
    preg_addr_t prb_raddr_0;
    preg_addr_t prb_raddr_1;
    lane_vec_t  prb_rdata_0;
    lane_vec_t  prb_rdata_1;

    logic       starve_mode;

    // Requesters plus the register block itself.
    modport master (
        output wr_req_valid, wr_req_warp, wr_req_addr, wr_req_mask, wr_req_data,
        input  wr_req_ready,
        output rd_req_valid, rd_req_warp, rd_req_addr, rd_req_mask,
        input  rd_req_ready, rd_rsp_valid, rd_rsp_data,
        input  prb_warp_selector, prb_write_en, prb_waddr, prb_wdata,
        input  prb_read_en_0, prb_read_en_1, prb_raddr_0, prb_raddr_1,
        output prb_rdata_0, prb_rdata_1,
        input  starve_mode
    );

    // The scheduler.
    modport slave (
        input  wr_req_valid, wr_req_warp, wr_req_addr, wr_req_mask, wr_req_data,
        output wr_req_ready,
        input  rd_req_valid, rd_req_warp, rd_req_addr, rd_req_mask,
        output rd_req_ready, rd_rsp_valid, rd_rsp_data,
        output prb_warp_selector, prb_write_en, prb_waddr, prb_wdata,
        output prb_read_en_0, prb_read_en_1, prb_raddr_0, prb_raddr_1,
        input  prb_rdata_0, prb_rdata_1,
        output starve_mode
    );

endinterface

// File: rtl/pred_rr_picker.sv
// Round-robin picker: first requester that is also eligible, searching upward from ptr_i.
module pred_rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    elig_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            vld_o
);

    logic [N-1:0] cand;

    assign cand = req_i & elig_i;

    // Scan candidates in rotated order and take the first hit.
    always_comb begin
        int unsigned j;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found && cand[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
                found    = 1'b1;
            end
        end
        vld_o = found;
    end

endmodule

// File: rtl/predicate_access_scheduler.sv
// Shares the predicate register block's write port and two read ports among requesters,
// one warp per cycle, with a starvation guard that periodically forces read priority.
module predicate_access_scheduler
    import predicate_sched_pkg::*;
(
    input logic                         clk,
    input logic                         rst,
    predicate_access_scheduler_if.slave bus_io
);

    warp_id_t   wr_warp [NUM_WR];
    preg_addr_t wr_addr [NUM_WR];
    lane_vec_t  wr_mask [NUM_WR];
    lane_vec_t  wr_data [NUM_WR];
    warp_id_t   rd_warp [NUM_RD];
    preg_addr_t rd_addr [NUM_RD];
    lane_vec_t  rd_mask [NUM_RD];

    logic [WR_IDX_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [RD_IDX_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [STARVE_W-1:0]     starve_cnt_q, starve_cnt_d;
    logic [NUM_RD-1:0]       rsp_valid_q, rsp_valid_d;
    logic [NUM_RD*LANES-1:0] rsp_data_q, rsp_data_d;

    logic                starve;
    logic [NUM_WR-1:0]   wr_req, w_gnt;
    logic [WR_IDX_W-1:0] w_idx;
    logic                w_vld;
    logic [NUM_RD-1:0]   rd_req, rd0_elig, rd0_gnt, rd1_elig, rd1_gnt;
    logic [RD_IDX_W-1:0] rd0_idx, rd1_idx, rd_last;
    logic                rd0_vld, rd1_vld;
    warp_id_t            sel_warp;

    // Unpack the flat request buses into per-requester fields.
    always_comb begin
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wr_warp[i] = bus_io.wr_req_warp[i*WARP_W +: WARP_W];
            wr_addr[i] = bus_io.wr_req_addr[i*PREG_AW +: PREG_AW];
            wr_mask[i] = bus_io.wr_req_mask[i*LANES +: LANES];
            wr_data[i] = bus_io.wr_req_data[i*LANES +: LANES];
        end
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_warp[i] = bus_io.rd_req_warp[i*WARP_W +: WARP_W];
            rd_addr[i] = bus_io.rd_req_addr[i*PREG_AW +: PREG_AW];
            rd_mask[i] = bus_io.rd_req_mask[i*LANES +: LANES];
        end
    end

    assign starve = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
    // Nothing is granted while reset is held.
    assign wr_req = (rst || starve) ? '0 : bus_io.wr_req_valid;
    assign rd_req = rst ? '0 : bus_io.rd_req_valid;

    pred_rr_picker #(.N(NUM_WR)) u_wr_pick (
        .req_i  (wr_req),
        .elig_i ({NUM_WR{1'b1}}),
        .ptr_i  (wr_ptr_q),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx),
        .vld_o  (w_vld)
    );

    // With a write winner, reads must share its warp and avoid its register (stale data).
    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd0_elig[i] = w_vld ? ((rd_warp[i] == wr_warp[w_idx]) && (rd_addr[i] != wr_addr[w_idx]))
                                : 1'b1;
        end
    end

    pred_rr_picker #(.N(NUM_RD)) u_rd0_pick (
        .req_i  (rd_req),
        .elig_i (rd0_elig),
        .ptr_i  (rd_ptr_q),
        .gnt_o  (rd0_gnt),
        .idx_o  (rd0_idx),
        .vld_o  (rd0_vld)
    );

    assign sel_warp = w_vld   ? wr_warp[w_idx]   :
                      rd0_vld ? rd_warp[rd0_idx] : '0;

    // Second read port: same constraints, same warp, excluding the first winner.
    always_comb begin
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd1_elig[i] = rd0_elig[i] && !rd0_gnt[i] && (rd_warp[i] == sel_warp);
        end
    end

    pred_rr_picker #(.N(NUM_RD)) u_rd1_pick (
        .req_i  (rd_req),
        .elig_i (rd1_elig),
        .ptr_i  (rd_ptr_q),
        .gnt_o  (rd1_gnt),
        .idx_o  (rd1_idx),
        .vld_o  (rd1_vld)
    );

    assign bus_io.wr_req_ready      = w_gnt;
    assign bus_io.rd_req_ready      = rd0_gnt | rd1_gnt;
    assign bus_io.prb_warp_selector = sel_warp;
    assign bus_io.prb_write_en      = w_vld ? wr_mask[w_idx] : '0;
    assign bus_io.prb_waddr         = w_vld ? wr_addr[w_idx] : '0;
    assign bus_io.prb_wdata         = w_vld ? wr_data[w_idx] : '0;
    assign bus_io.prb_read_en_0     = rd0_vld ? rd_mask[rd0_idx] : '0;
    assign bus_io.prb_raddr_0       = rd0_vld ? rd_addr[rd0_idx] : '0;
    assign bus_io.prb_read_en_1     = rd1_vld ? rd_mask[rd1_idx] : '0;
    assign bus_io.prb_raddr_1       = rd1_vld ? rd_addr[rd1_idx] : '0;
    assign bus_io.rd_rsp_valid      = rsp_valid_q;
    assign bus_io.rd_rsp_data       = rsp_data_q;
    assign bus_io.starve_mode       = starve;

    // Port 1 always follows port 0 in rotation order, so it is the last grant when present.
    assign rd_last = rd1_vld ? rd1_idx : rd0_idx;

    // Pointer, starvation and response next-state.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        starve_cnt_d = starve_cnt_q;
        rsp_valid_d  = rd0_gnt | rd1_gnt;
        rsp_data_d   = rsp_data_q;

        if (w_vld) begin
            wr_ptr_d = (w_idx == WR_IDX_W'(NUM_WR - 1)) ? '0 : w_idx + 1'b1;
        end
        if (rd0_vld) begin
            rd_ptr_d = (rd_last == RD_IDX_W'(NUM_RD - 1)) ? '0 : rd_last + 1'b1;
        end

        if (rd0_vld) begin
            starve_cnt_d = '0;
        end else if ((|bus_io.rd_req_valid) && !starve) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (rd0_gnt[i]) begin
                rsp_data_d[i*LANES +: LANES] = bus_io.prb_rdata_0 & rd_mask[i];
            end else if (rd1_gnt[i]) begin
                rsp_data_d[i*LANES +: LANES] = bus_io.prb_rdata_1 & rd_mask[i];
            end
        end
    end

    // State registers; reset also drops any response in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            starve_cnt_q <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_predicate_access_scheduler.sv
// Directed bench for predicate_access_scheduler with a behavioural predicate register block.
module tb_predicate_access_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    predicate_access_scheduler_if bus ();

    predicate_access_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    // Register block model: combinational read, lane-masked write at the clock edge.
    logic [15:0] mem [16][16];

    assign bus.prb_rdata_0 = mem[bus.prb_warp_selector][bus.prb_raddr_0];
    assign bus.prb_rdata_1 = mem[bus.prb_warp_selector][bus.prb_raddr_1];

    always @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 16; w++)
                for (int a = 0; a < 16; a++) mem[w][a] <= '0;
        end else begin
            for (int l = 0; l < 16; l++)
                if (bus.prb_write_en[l]) mem[bus.prb_warp_selector][bus.prb_waddr][l] <= bus.prb_wdata[l];
        end
    end

    task automatic clear_reqs();
        bus.wr_req_valid = '0; bus.wr_req_warp = '0; bus.wr_req_addr = '0;
        bus.wr_req_mask  = '0; bus.wr_req_data = '0;
        bus.rd_req_valid = '0; bus.rd_req_warp = '0; bus.rd_req_addr = '0;
        bus.rd_req_mask  = '0;
    endtask

    task automatic set_wr(input int i, input logic [3:0] warp, input logic [3:0] addr,
                          input logic [15:0] mask, input logic [15:0] data);
        bus.wr_req_valid[i]        = 1'b1;
        bus.wr_req_warp[i*4 +: 4]  = warp;
        bus.wr_req_addr[i*4 +: 4]  = addr;
        bus.wr_req_mask[i*16 +: 16] = mask;
        bus.wr_req_data[i*16 +: 16] = data;
    endtask

    task automatic set_rd(input int i, input logic [3:0] warp, input logic [3:0] addr,
                          input logic [15:0] mask);
        bus.rd_req_valid[i]        = 1'b1;
        bus.rd_req_warp[i*4 +: 4]  = warp;
        bus.rd_req_addr[i*4 +: 4]  = addr;
        bus.rd_req_mask[i*16 +: 16] = mask;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set_wr(0, 4'd1, 4'd1, 16'hFFFF, 16'h1234);
        set_rd(0, 4'd1, 4'd2, 16'hFFFF);
        #1;
        checks++; if (bus.wr_req_ready !== 2'b00) begin errors++;
            $display("FAIL rst_wr_ready got %b exp 00", bus.wr_req_ready); end
        checks++; if (bus.rd_req_ready !== 4'b0000) begin errors++;
            $display("FAIL rst_rd_ready got %b exp 0000", bus.rd_req_ready); end
        checks++; if (bus.prb_write_en !== 16'h0 || bus.prb_read_en_0 !== 16'h0) begin errors++;
            $display("FAIL rst_prb_en got %h/%h exp 0/0", bus.prb_write_en, bus.prb_read_en_0); end
        @(negedge clk);
        clear_reqs();
        rst = 1'b0;
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0000 || bus.rd_rsp_data !== 64'h0) begin errors++;
            $display("FAIL rst_rsp got %b/%h exp 0/0", bus.rd_rsp_valid, bus.rd_rsp_data); end
        checks++; if (bus.starve_mode !== 1'b0 || bus.prb_warp_selector !== 4'h0) begin errors++;
            $display("FAIL rst_idle got %b/%h exp 0/0", bus.starve_mode, bus.prb_warp_selector); end
    endtask

    task automatic test_write_alternation();
        logic [1:0] exp_gnt;
        logic [3:0] exp_warp;
        @(negedge clk);
        set_wr(0, 4'd1, 4'd2, 16'hFFFF, 16'h1111);
        set_wr(1, 4'd4, 4'd3, 16'hFFFF, 16'h4444);
        for (int c = 0; c < 4; c++) begin
            exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_warp = (c % 2 == 0) ? 4'd1 : 4'd4;
            #1;
            checks++; if (bus.wr_req_ready !== exp_gnt || bus.prb_warp_selector !== exp_warp) begin
                errors++;
                $display("FAIL alt_grant cyc %0d got %b/%h exp %b/%h", c, bus.wr_req_ready,
                         bus.prb_warp_selector, exp_gnt, exp_warp);
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_four_readers();
        @(negedge clk);
        set_rd(0, 4'd1, 4'd2, 16'hFFFF);
        set_rd(1, 4'd1, 4'd2, 16'h00F0);
        set_rd(2, 4'd1, 4'd0, 16'hFFFF);
        set_rd(3, 4'd1, 4'd2, 16'hF000);
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0011 || bus.prb_read_en_1 !== 16'h00F0) begin errors++;
            $display("FAIL rd4_first got %b/%h exp 0011/00f0", bus.rd_req_ready, bus.prb_read_en_1); end
        @(negedge clk);
        bus.rd_req_valid[0] = 1'b0;
        bus.rd_req_valid[1] = 1'b0;
        #1;
        checks++; if (bus.rd_req_ready !== 4'b1100) begin errors++;
            $display("FAIL rd4_second got %b exp 1100", bus.rd_req_ready); end
        checks++; if (bus.rd_rsp_valid !== 4'b0011 || bus.rd_rsp_data[31:0] !== 32'h0010_1111) begin
            errors++;
            $display("FAIL rd4_rsp01 got %b/%h exp 0011/00101111", bus.rd_rsp_valid,
                     bus.rd_rsp_data[31:0]);
        end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b1100 || bus.rd_rsp_data[63:32] !== 32'h1000_0000) begin
            errors++;
            $display("FAIL rd4_rsp23 got %b/%h exp 1100/10000000", bus.rd_rsp_valid,
                     bus.rd_rsp_data[63:32]);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        set_wr(0, 4'd3, 4'd5, 16'hFFFF, 16'hA5A5);
        #1;
        checks++; if (bus.wr_req_ready !== 2'b01 || bus.prb_write_en !== 16'hFFFF) begin errors++;
            $display("FAIL sw_grant got %b/%h exp 01/ffff", bus.wr_req_ready, bus.prb_write_en); end
        checks++; if (bus.prb_warp_selector !== 4'd3 || bus.prb_waddr !== 4'd5 ||
                      bus.prb_wdata !== 16'hA5A5) begin errors++;
            $display("FAIL sw_drive got %h/%h/%h exp 3/5/a5a5", bus.prb_warp_selector,
                     bus.prb_waddr, bus.prb_wdata); end
        @(negedge clk);
        clear_reqs();
        set_rd(0, 4'd3, 4'd5, 16'hFFFF);
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0001 || bus.prb_raddr_0 !== 4'd5) begin errors++;
            $display("FAIL sw_rd_grant got %b/%h exp 0001/5", bus.rd_req_ready, bus.prb_raddr_0); end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0001 || bus.rd_rsp_data[15:0] !== 16'hA5A5) begin
            errors++;
            $display("FAIL sw_rsp got %b/%h exp 0001/a5a5", bus.rd_rsp_valid, bus.rd_rsp_data[15:0]);
        end
    endtask

    task automatic test_same_addr();
        @(negedge clk);
        set_wr(0, 4'd2, 4'd7, 16'hFFFF, 16'h1234);
        set_rd(0, 4'd2, 4'd7, 16'hFFFF);
        set_rd(1, 4'd2, 4'd1, 16'hFFFF);
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0010 || bus.prb_raddr_0 !== 4'd1 ||
                      bus.prb_read_en_1 !== 16'h0) begin errors++;
            $display("FAIL sa_defer got %b/%h/%h exp 0010/1/0", bus.rd_req_ready, bus.prb_raddr_0,
                     bus.prb_read_en_1); end
        checks++; if (bus.wr_req_ready !== 2'b01) begin errors++;
            $display("FAIL sa_wr got %b exp 01", bus.wr_req_ready); end
        @(negedge clk);
        bus.wr_req_valid    = '0;
        bus.rd_req_valid[1] = 1'b0;
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0001 || bus.prb_raddr_0 !== 4'd7) begin errors++;
            $display("FAIL sa_retry got %b/%h exp 0001/7", bus.rd_req_ready, bus.prb_raddr_0); end
        checks++; if (bus.rd_rsp_valid !== 4'b0010 || bus.rd_rsp_data[31:16] !== 16'h0) begin errors++;
            $display("FAIL sa_rsp1 got %b/%h exp 0010/0", bus.rd_rsp_valid, bus.rd_rsp_data[31:16]); end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0001 || bus.rd_rsp_data[15:0] !== 16'h1234) begin
            errors++;
            $display("FAIL sa_rsp0 got %b/%h exp 0001/1234", bus.rd_rsp_valid, bus.rd_rsp_data[15:0]);
        end
    endtask

    task automatic test_masks();
        @(negedge clk);
        set_wr(0, 4'd3, 4'd5, 16'h00FF, 16'h0000);
        #1;
        checks++; if (bus.prb_write_en !== 16'h00FF) begin errors++;
            $display("FAIL mk_wen got %h exp 00ff", bus.prb_write_en); end
        @(negedge clk);
        clear_reqs();
        set_rd(1, 4'd3, 4'd5, 16'hFFFF);
        set_rd(2, 4'd3, 4'd5, 16'h0F0F);
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0110 || bus.prb_read_en_1 !== 16'h0F0F) begin errors++;
            $display("FAIL mk_dual got %b/%h exp 0110/0f0f", bus.rd_req_ready, bus.prb_read_en_1); end
        @(negedge clk);
        clear_reqs();
        set_rd(1, 4'd3, 4'd5, 16'h0000);
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0110 || bus.rd_rsp_data[47:16] !== 32'h0500_A500) begin
            errors++;
            $display("FAIL mk_rsp got %b/%h exp 0110/0500a500", bus.rd_rsp_valid,
                     bus.rd_rsp_data[47:16]);
        end
        checks++; if (bus.rd_req_ready !== 4'b0010 || bus.prb_read_en_0 !== 16'h0) begin errors++;
            $display("FAIL mk_zero_grant got %b/%h exp 0010/0", bus.rd_req_ready, bus.prb_read_en_0); end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0010 || bus.rd_rsp_data[31:16] !== 16'h0) begin errors++;
            $display("FAIL mk_zero_rsp got %b/%h exp 0010/0", bus.rd_rsp_valid, bus.rd_rsp_data[31:16]); end
    endtask

    task automatic test_starvation();
        @(negedge clk);
        set_wr(0, 4'd0, 4'd0, 16'hFFFF, 16'h0BAD);
        set_rd(0, 4'd9, 4'd4, 16'hFFFF);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (bus.starve_mode !== 1'b0 || bus.wr_req_ready !== 2'b01 ||
                          bus.rd_req_ready !== 4'b0000) begin errors++;
                $display("FAIL sv_starved cyc %0d got %b/%b/%b exp 0/01/0000", c, bus.starve_mode,
                         bus.wr_req_ready, bus.rd_req_ready); end
            @(negedge clk);
        end
        #1;
        checks++; if (bus.starve_mode !== 1'b1 || bus.wr_req_ready !== 2'b00 ||
                      bus.rd_req_ready !== 4'b0001) begin errors++;
            $display("FAIL sv_force got %b/%b/%b exp 1/00/0001", bus.starve_mode, bus.wr_req_ready,
                     bus.rd_req_ready); end
        checks++; if (bus.prb_warp_selector !== 4'd9 || bus.prb_write_en !== 16'h0) begin errors++;
            $display("FAIL sv_drive got %h/%h exp 9/0", bus.prb_warp_selector, bus.prb_write_en); end
        @(negedge clk);
        bus.rd_req_valid[0] = 1'b0;
        #1;
        checks++; if (bus.starve_mode !== 1'b0 || bus.wr_req_ready !== 2'b01) begin errors++;
            $display("FAIL sv_clear got %b/%b exp 0/01", bus.starve_mode, bus.wr_req_ready); end
        checks++; if (bus.rd_rsp_valid !== 4'b0001 || bus.rd_rsp_data[15:0] !== 16'h0) begin errors++;
            $display("FAIL sv_rsp got %b/%h exp 0001/0", bus.rd_rsp_valid, bus.rd_rsp_data[15:0]); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        set_rd(0, 4'd1, 4'd2, 16'hFFFF);
        #1;
        checks++; if (bus.rd_req_ready !== 4'b0001) begin errors++;
            $display("FAIL rm_grant got %b exp 0001", bus.rd_req_ready); end
        @(negedge clk);
        clear_reqs();
        rst = 1'b1;
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b0000 || bus.rd_rsp_data !== 64'h0) begin errors++;
            $display("FAIL rm_drop got %b/%h exp 0/0", bus.rd_rsp_valid, bus.rd_rsp_data); end
        @(negedge clk);
        set_wr(0, 4'd5, 4'd1, 16'hFFFF, 16'h5555);
        set_wr(1, 4'd6, 4'd1, 16'hFFFF, 16'h6666);
        set_rd(0, 4'd5, 4'd9, 16'h000F);
        set_rd(3, 4'd5, 4'd9, 16'hF000);
        #1;
        checks++; if (bus.wr_req_ready !== 2'b00 || bus.rd_req_ready !== 4'b0000 ||
                      bus.prb_write_en !== 16'h0 || bus.rd_rsp_valid !== 4'b0000) begin errors++;
            $display("FAIL rm_held got %b/%b/%h/%b exp 00/0000/0/0000", bus.wr_req_ready,
                     bus.rd_req_ready, bus.prb_write_en, bus.rd_rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.wr_req_ready !== 2'b01 || bus.prb_warp_selector !== 4'd5) begin errors++;
            $display("FAIL rm_wr_ptr got %b/%h exp 01/5", bus.wr_req_ready, bus.prb_warp_selector); end
        checks++; if (bus.rd_req_ready !== 4'b1001 || bus.prb_read_en_0 !== 16'h000F) begin errors++;
            $display("FAIL rm_rd_ptr got %b/%h exp 1001/000f", bus.rd_req_ready, bus.prb_read_en_0); end
        @(negedge clk);
        clear_reqs();
        #1;
        checks++; if (bus.rd_rsp_valid !== 4'b1001) begin errors++;
            $display("FAIL rm_rsp got %b exp 1001", bus.rd_rsp_valid); end
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_write_alternation();
        test_four_readers();
        test_single_write();
        test_same_addr();
        test_masks();
        test_starvation();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/predicate_access_scheduler.md
# predicate_access_scheduler

Arbitrates the predicate register block's single write port and two read ports among multiple requesters. Write requesters are compare/writeback and split/join units; read requesters are operand-fetch slots. Each cycle it selects one warp, drives that block's warp selector, enables and addresses, and returns registered, lane-masked read data one cycle after grant. A starvation counter guarantees reads make progress under sustained write traffic.

## Interface
- LANES, 16, lanes per predicate register
- NUM_WARPS, 16, warps (warp id width WARP_W = 4)
- NUM_PREGS, 16, predicate registers per warp (address width PREG_AW = 4)
- NUM_WR, 2, write requesters
- NUM_RD, 4, read requesters
- STARVE_LIMIT, 4, consecutive read-starved cycles before forcing read priority
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_req_valid / wr_req_ready  in / out  NUM_WR  write handshake per requester
- wr_req_warp / wr_req_addr  in  NUM_WR*4 each  target warp / register
- wr_req_mask / wr_req_data  in  NUM_WR*LANES each  lane write enables / lane data
- rd_req_valid / rd_req_ready  in / out  NUM_RD  read handshake per requester
- rd_req_warp / rd_req_addr  in  NUM_RD*4 each  source warp / register
- rd_req_mask  in  NUM_RD*LANES  lanes requested
- rd_rsp_valid  out  NUM_RD  one-cycle response strobe
- rd_rsp_data  out  NUM_RD*LANES  response data, masked-off lanes 0
- prb_warp_selector  out  4  warp for this cycle
- prb_write_en  out  LANES;  prb_waddr  out  4;  prb_wdata  out  LANES
- prb_read_en_0 / prb_read_en_1  out  LANES each;  prb_raddr_0 / prb_raddr_1  out  4 each
- prb_rdata_0 / prb_rdata_1  in  LANES each  combinational read data from the register block
- starve_mode  out  1  high in a read-priority cycle

## Operation
- Transfer on valid && ready. Ready is the combinational grant. Requesters hold valid and payload stable until ready.
- Write-priority mode (starve_cnt < STARVE_LIMIT):
  - Pick write winner W round-robin from wr_ptr. Warp = W.warp.
  - Eligible reads: valid, same warp, and addr != W.addr. The same-cycle write lands at the clock edge, so a same-address read would return stale data; it is deferred.
  - Pick up to two eligible reads round-robin from rd_ptr. First goes to port 0, second to port 1.
  - No valid writer: warp = warp of first RR read winner; second read must match that warp.
- Read-priority mode (starve_cnt == STARVE_LIMIT): no write granted; reads picked as above using first read's warp.
- PRB drive: write_en = W.mask, read_en_n = winner mask, else 0. Idle outputs (addresses, wdata, warp_selector) = 0.
- Pointer updates:
  - wr_ptr <= W+1 mod NUM_WR on write grant.
  - rd_ptr <= (last granted read index)+1 mod NUM_RD on any read grant.
- starve_cnt:
  - Clears when any read is granted.
  - Increments (saturating at STARVE_LIMIT) when >=1 read is valid and none is granted.
  - Unchanged otherwise.
- Response: rd_rsp_data[i] <= prb_rdata_port & mask, captured at the grant edge; rd_rsp_valid[i] pulses next cycle. Two responses may coincide.

## Timing
- Grant and PRB drive are combinational in cycle N; the write commits at the end of N; read response is valid in N+1 (latency 1).
- Back-to-back: a requester may issue a new request in the cycle its response is valid. A read of a register written in N is grantable from N+1 and returns the new value.
- Reset values: rd_rsp_valid 0, rd_rsp_data 0, wr_ptr 0, rd_ptr 0, starve_cnt 0, starve_mode 0.
- While rst is high, all readys and PRB enables are 0.
- Reset mid-operation: responses still in flight are dropped, and no rd_rsp_valid follows.
- Masks of all zero are legal: the request is granted, the PRB enable is 0, and the response is data 0 with valid pulsed.

## Structure
- Package predicate_sched_pkg holds:
  - LANES, WARP_W, PREG_AW constants;
  - typedefs warp_id_t, preg_addr_t, lane_vec_t.
- Sub-module pred_rr_picker: request vector, start pointer and eligibility mask in; one-hot grant and index out.
  - Instantiated once for writes.
  - Instantiated twice for reads; the second instance excludes the first winner.

## Test plan
- Single write, warp 3, addr 5, mask FFFF, data A5A5; read warp 3 addr 5 next cycle -> write_en FFFF in cycle 0; rd_rsp_data A5A5 in cycle 2.
- Write warp 2 addr 7 with reads to warp 2 addr 7 and warp 2 addr 1 in the same cycle -> addr 1 read granted on port 0; addr 7 read deferred one cycle and returns new data.
- Both writers valid continuously, warps 1 and 4 -> grants alternate 0,1,0,1; warp_selector alternates 1,4.
- Four readers, same warp, all valid -> grants {0,1} then {2,3}; two rd_rsp_valid pulses per cycle.
- Writer continuously on warp 0 while a reader targets warp 9 -> after 4 starved cycles starve_mode=1, read granted, write_ready 0 that cycle, starve_cnt clears.
- Assert rst in the cycle after a read grant -> no rd_rsp_valid; all outputs at reset values; first post-reset grant uses pointer 0.
